// File: rtl/qpu_exu_disp_oitf_if.sv
// qpu_exu_disp_oitf_if: dispatch-side instruction handshake and registered ALU issue bundle.
interface qpu_exu_disp_oitf_if #(
    parameter int XLEN      = 32,
    parameter int PC_W      = 32,
    parameter int RFIDX_W   = 5,
    parameter int DECINFO_W = 32,
    parameter int QUBIT_NUM = 8,
    parameter int PTR_W     = 2
);
    logic                 disp_i_valid;
    logic                 disp_i_ready;
    logic                 disp_i_rs1en;
    logic                 disp_i_rs2en;
    logic [RFIDX_W-1:0]   disp_i_rs1idx;
    logic [RFIDX_W-1:0]   disp_i_rs2idx;
    logic [XLEN-1:0]      disp_i_rs1;
    logic [XLEN-1:0]      disp_i_rs2;
    logic                 disp_i_rdwen;
    logic [RFIDX_W-1:0]   disp_i_rdidx;
    logic [DECINFO_W-1:0] disp_i_info;
    logic [XLEN-1:0]      disp_i_imm;
    logic [PC_W-1:0]      disp_i_pc;
    logic                 disp_i_measure;
    logic                 disp_i_fmr;
    logic [QUBIT_NUM-1:0] disp_i_qubitlist;
    logic                 disp_o_alu_valid;
    logic                 disp_o_alu_ready;
    logic [XLEN-1:0]      disp_o_alu_rs1;
    logic [XLEN-1:0]      disp_o_alu_rs2;
    logic                 disp_o_alu_rdwen;
    logic [RFIDX_W-1:0]   disp_o_alu_rdidx;
    logic [DECINFO_W-1:0] disp_o_alu_info;
    logic [XLEN-1:0]      disp_o_alu_imm;
    logic [PC_W-1:0]      disp_o_alu_pc;
    logic                 disp_o_alu_measure;
    logic                 disp_o_alu_fmr;
    logic [PTR_W-1:0]     disp_o_alu_itag;
    logic                 disp_o_alu_longpipe;

    modport slave (
        input  disp_i_valid, disp_i_rs1en, disp_i_rs2en, disp_i_rs1idx, disp_i_rs2idx,
               disp_i_rs1, disp_i_rs2, disp_i_rdwen, disp_i_rdidx, disp_i_info, disp_i_imm,
               disp_i_pc, disp_i_measure, disp_i_fmr, disp_i_qubitlist, disp_o_alu_ready,
        output disp_i_ready, disp_o_alu_valid, disp_o_alu_rs1, disp_o_alu_rs2, disp_o_alu_rdwen,
               disp_o_alu_rdidx, disp_o_alu_info, disp_o_alu_imm, disp_o_alu_pc,
               disp_o_alu_measure, disp_o_alu_fmr, disp_o_alu_itag, disp_o_alu_longpipe
    );

    modport master (
        output disp_i_valid, disp_i_rs1en, disp_i_rs2en, disp_i_rs1idx, disp_i_rs2idx,
               disp_i_rs1, disp_i_rs2, disp_i_rdwen, disp_i_rdidx, disp_i_info, disp_i_imm,
               disp_i_pc, disp_i_measure, disp_i_fmr, disp_i_qubitlist, disp_o_alu_ready,
        input  disp_i_ready, disp_o_alu_valid, disp_o_alu_rs1, disp_o_alu_rs2, disp_o_alu_rdwen,
               disp_o_alu_rdidx, disp_o_alu_info, disp_o_alu_imm, disp_o_alu_pc,
               disp_o_alu_measure, disp_o_alu_fmr, disp_o_alu_itag, disp_o_alu_longpipe
    );
endinterface

// File: rtl/qpu_exu_disp_oitf.sv
// qpu_exu_disp_oitf: QPU dispatcher with integrated outstanding-instruction tracker;
// stalls on register/qubit hazards against in-flight long-pipe entries and issues through one register stage.
module qpu_exu_disp_oitf #(
    parameter int XLEN       = 32,
    parameter int PC_W       = 32,
    parameter int RFIDX_W    = 5,
    parameter int DECINFO_W  = 32,
    parameter int QUBIT_NUM  = 8,
    parameter int OITF_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    qpu_exu_disp_oitf_if.slave  disp,
    input  logic                ret_ena,
    input  logic                flush_ena,
    output logic                oitf_empty,
    output logic                oitf_full,
    output logic [PTR_W:0]      oitf_count
);
    typedef struct packed {
        logic [XLEN-1:0]      rs1;
        logic [XLEN-1:0]      rs2;
        logic                 rdwen;
        logic [RFIDX_W-1:0]   rdidx;
        logic [DECINFO_W-1:0] info;
        logic [XLEN-1:0]      imm;
        logic [PC_W-1:0]      pc;
        logic                 measure;
        logic                 fmr;
        logic                 longpipe;
        logic [PTR_W-1:0]     itag;
    } pay_t;

    logic [OITF_DEPTH-1:0]                ent_v_q, ent_v_d;
    logic [OITF_DEPTH-1:0]                ent_rdwen_q, ent_rdwen_d;
    logic [OITF_DEPTH-1:0]                ent_meas_q, ent_meas_d;
    logic [OITF_DEPTH-1:0][RFIDX_W-1:0]   ent_rdidx_q, ent_rdidx_d;
    logic [OITF_DEPTH-1:0][QUBIT_NUM-1:0] ent_ql_q, ent_ql_d;
    logic [PTR_W-1:0]                     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PTR_W:0]                       count_q, count_d;
    logic                                 valid_q, valid_d;
    pay_t                                 pay_q, pay_d;
    logic                                 hazard, need_alloc, hs, alloc, ret_do;

    assign need_alloc = disp.disp_i_rdwen | disp.disp_i_measure;
    assign oitf_empty = (count_q == '0);
    assign oitf_full  = (count_q == (PTR_W+1)'(OITF_DEPTH));
    assign oitf_count = count_q;

    // Hazards look only at registered entries; a retire in this cycle frees nothing until the next.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < OITF_DEPTH; i++) begin
            hazard |= ent_v_q[i] & ent_rdwen_q[i] & (
                      (disp.disp_i_rs1en & (|disp.disp_i_rs1idx) & (ent_rdidx_q[i] == disp.disp_i_rs1idx))
                    | (disp.disp_i_rs2en & (|disp.disp_i_rs2idx) & (ent_rdidx_q[i] == disp.disp_i_rs2idx))
                    | (disp.disp_i_rdwen & (|disp.disp_i_rdidx)  & (ent_rdidx_q[i] == disp.disp_i_rdidx)));
            hazard |= ent_v_q[i] & ent_meas_q[i] & (disp.disp_i_fmr | disp.disp_i_measure)
                    & (|(ent_ql_q[i] & disp.disp_i_qubitlist));
        end
    end

    assign disp.disp_i_ready = rst_n & ~hazard & ~(need_alloc & oitf_full)
                             & (~valid_q | disp.disp_o_alu_ready) & ~flush_ena;
    assign hs     = disp.disp_i_valid & disp.disp_i_ready;
    assign alloc  = hs & need_alloc;
    assign ret_do = ret_ena & ~oitf_empty & ~flush_ena;

    always_comb begin
        ent_v_d     = ent_v_q;
        ent_rdwen_d = ent_rdwen_q;
        ent_meas_d  = ent_meas_q;
        ent_rdidx_d = ent_rdidx_q;
        ent_ql_d    = ent_ql_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        valid_d     = valid_q;
        pay_d       = pay_q;
        if (flush_ena) begin
            ent_v_d = '0;
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            valid_d = 1'b0;
        end else begin
            if (ret_do) begin
                ent_v_d[rptr_q] = 1'b0;
                rptr_d          = rptr_q + PTR_W'(1);
            end
            if (hs) begin
                valid_d        = 1'b1;
                pay_d.rs1      = disp.disp_i_rs1;
                pay_d.rs2      = disp.disp_i_rs2;
                pay_d.rdwen    = disp.disp_i_rdwen;
                pay_d.rdidx    = disp.disp_i_rdidx;
                pay_d.info     = disp.disp_i_info;
                pay_d.imm      = disp.disp_i_imm;
                pay_d.pc       = disp.disp_i_pc;
                pay_d.measure  = disp.disp_i_measure;
                pay_d.fmr      = disp.disp_i_fmr;
                pay_d.longpipe = need_alloc;
                pay_d.itag     = wptr_q;
            end else if (disp.disp_o_alu_ready) begin
                valid_d = 1'b0;
            end
            if (alloc) begin
                ent_v_d[wptr_q]     = 1'b1;
                ent_rdwen_d[wptr_q] = disp.disp_i_rdwen;
                ent_rdidx_d[wptr_q] = disp.disp_i_rdidx;
                ent_meas_d[wptr_q]  = disp.disp_i_measure;
                ent_ql_d[wptr_q]    = disp.disp_i_qubitlist;
                wptr_d              = wptr_q + PTR_W'(1);
            end
            count_d = count_q + (PTR_W+1)'(alloc) - (PTR_W+1)'(ret_do);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_v_q     <= '0;
            ent_rdwen_q <= '0;
            ent_meas_q  <= '0;
            ent_rdidx_q <= '0;
            ent_ql_q    <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            pay_q       <= '0;
        end else begin
            ent_v_q     <= ent_v_d;
            ent_rdwen_q <= ent_rdwen_d;
            ent_meas_q  <= ent_meas_d;
            ent_rdidx_q <= ent_rdidx_d;
            ent_ql_q    <= ent_ql_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            pay_q       <= pay_d;
        end
    end

    assign disp.disp_o_alu_valid    = valid_q;
    assign disp.disp_o_alu_rs1      = pay_q.rs1;
    assign disp.disp_o_alu_rs2      = pay_q.rs2;
    assign disp.disp_o_alu_rdwen    = pay_q.rdwen;
    assign disp.disp_o_alu_rdidx    = pay_q.rdidx;
    assign disp.disp_o_alu_info     = pay_q.info;
    assign disp.disp_o_alu_imm      = pay_q.imm;
    assign disp.disp_o_alu_pc       = pay_q.pc;
    assign disp.disp_o_alu_measure  = pay_q.measure;
    assign disp.disp_o_alu_fmr      = pay_q.fmr;
    assign disp.disp_o_alu_itag     = pay_q.itag;
    assign disp.disp_o_alu_longpipe = pay_q.longpipe;
endmodule
